// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with sub-word load/store support.
//   - drives the D-cache interface combinationally from the EX/MEM inputs
//   - aligns/extends load data, replicates store data, generates byte enables
//   - detects misaligned accesses and suppresses the cache request for them
//   - IDLE/WAIT FSM tracks cache wait states; stall_o holds upstream
//   - owns the MEM/WB register and a saturating stall-cycle counter
// Ports:
//   clk, rst (sync, active-high), flush
//   EX/MEM inputs : valid_in, alu_result_in, mem_wdata_in, memrd_in, memwr_in,
//                   funct3_in, PC_step_in, rd_in, mem2reg_in, regwr_in, jump_in, mul_i
//   MEM/WB outputs: alu_result_out, mem_dat, PC_step_out, rd_out, mem2reg_out,
//                   regwr_out, jump_out, mul_o, valid_out, misalign_o
//   status        : stall_o, stall_cnt_o
//   D-cache       : DCACHE_stall, DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_be,
//                   DCACHE_rdata, DCACHE_wdata
//
// state  | meaning
// IDLE   | no outstanding stalled cache access
// WAIT   | cache busy on the current request; stages upstream are held
module mem_stage_lsu #(
    parameter int BIT_W       = 32,
    parameter bit SWAP_ENDIAN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [BIT_W-1:0]     alu_result_in,
    input  logic [BIT_W-1:0]     mem_wdata_in,
    input  logic                 memrd_in,
    input  logic                 memwr_in,
    input  logic [2:0]           funct3_in,
    input  logic [BIT_W-1:0]     PC_step_in,
    input  logic [4:0]           rd_in,
    input  logic                 mem2reg_in,
    input  logic                 regwr_in,
    input  logic                 jump_in,
    input  logic                 mul_i,
    output logic [BIT_W-1:0]     alu_result_out,
    output logic [BIT_W-1:0]     mem_dat,
    output logic [BIT_W-1:0]     PC_step_out,
    output logic [4:0]           rd_out,
    output logic                 mem2reg_out,
    output logic                 regwr_out,
    output logic                 jump_out,
    output logic                 mul_o,
    output logic                 valid_out,
    output logic                 misalign_o,
    output logic                 stall_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    input  logic                 DCACHE_stall,
    output logic                 DCACHE_ren,
    output logic                 DCACHE_wen,
    output logic [BIT_W-3:0]     DCACHE_addr,
    output logic [BIT_W/8-1:0]   DCACHE_be,
    input  logic [BIT_W-1:0]     DCACHE_rdata,
    output logic [BIT_W-1:0]     DCACHE_wdata
);

    localparam int LANES = BIT_W / 8;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state;

    function automatic logic [BIT_W-1:0] swap_data(input logic [BIT_W-1:0] d);
        logic [BIT_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = d[8*(LANES-1-i) +: 8];
        return r;
    endfunction

    function automatic logic [LANES-1:0] swap_be(input logic [LANES-1:0] b);
        logic [LANES-1:0] r;
        for (int i = 0; i < LANES; i++) r[i] = b[LANES-1-i];
        return r;
    endfunction

    logic [1:0]       off;
    logic [1:0]       size;
    logic             is_mem;
    logic             misaligned;
    logic             req;
    logic [LANES-1:0] be_mem;
    logic [BIT_W-1:0] wd_mem;
    logic [BIT_W-1:0] rd_norm;
    logic [BIT_W-1:0] rd_shift;
    logic [BIT_W-1:0] load_ext;
    logic             keep;

    assign off        = alu_result_in[1:0];
    assign size       = funct3_in[1:0];
    assign is_mem     = memrd_in | memwr_in;
    assign misaligned = is_mem & (((size == 2'b01) & off[0]) |
                                  ((size == 2'b10) & (off != 2'b00)));
    assign req        = valid_in & is_mem & ~misaligned;
    assign stall_o    = req & DCACHE_stall;

    always_comb begin
        be_mem = 4'b1111;
        wd_mem = mem_wdata_in;
        case (size)
            2'b00: begin
                be_mem = 4'b0001 << off;
                wd_mem = {LANES{mem_wdata_in[7:0]}};
            end
            2'b01: begin
                be_mem = 4'b0011 << off;
                wd_mem = {2{mem_wdata_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign DCACHE_ren   = req & memrd_in;
    assign DCACHE_wen   = req & memwr_in;
    assign DCACHE_addr  = alu_result_in[BIT_W-1:2];
    assign DCACHE_be    = SWAP_ENDIAN ? swap_be(be_mem) : be_mem;
    assign DCACHE_wdata = SWAP_ENDIAN ? swap_data(wd_mem) : wd_mem;

    // Bring the read word back to memory byte order, then drop the addressed
    // byte/half into the low bits before extension.
    assign rd_norm  = SWAP_ENDIAN ? swap_data(DCACHE_rdata) : DCACHE_rdata;
    assign rd_shift = rd_norm >> {off, 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (funct3_in)
            3'b000:  load_ext = {{(BIT_W-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{(BIT_W-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {{(BIT_W-8){1'b0}}, rd_shift[7:0]};
            3'b101:  load_ext = {{(BIT_W-16){1'b0}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // Only real, aligned, unflushed instructions may write the register file.
    assign keep = valid_in & ~misaligned & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (req & DCACHE_stall) state <= S_WAIT;
                S_WAIT: if (!DCACHE_stall)      state <= S_IDLE;
                default:                        state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_out <= '0;
            mem_dat        <= '0;
            PC_step_out    <= '0;
            rd_out         <= '0;
            mem2reg_out    <= 1'b0;
            regwr_out      <= 1'b0;
            jump_out       <= 1'b0;
            mul_o          <= 1'b0;
            valid_out      <= 1'b0;
            misalign_o     <= 1'b0;
        end else if (!stall_o) begin
            alu_result_out <= alu_result_in;
            mem_dat        <= load_ext;
            PC_step_out    <= PC_step_in;
            rd_out         <= rd_in;
            mul_o          <= mul_i;
            mem2reg_out    <= mem2reg_in & keep;
            regwr_out      <= regwr_in & keep;
            jump_out       <= jump_in & ~flush;
            valid_out      <= valid_in & ~flush;
            misalign_o     <= valid_in & misaligned & ~flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised successor to the single-width MEM stage. Adds sub-word loads/stores (byte, halfword, word) with byte enables, sign/zero extension, misalignment detection, an explicit wait-state FSM with a stall output, a flush input, and a saturating stall-cycle counter. Sits between the EX/MEM and MEM/WB boundaries, owns the MEM/WB register, and drives the D-cache interface combinationally.

Parameters:
BIT_W, 32, datapath width; must be 32 (4 byte lanes; LANES = BIT_W/8).
SWAP_ENDIAN, 1, 1 = byte-reverse data and byte enables at the D-cache boundary; 0 = pass through.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill the instruction entering MEM/WB this cycle
valid_in  in  1  EX/MEM slot holds a real instruction
alu_result_in  in  BIT_W  effective address / ALU result
mem_wdata_in  in  BIT_W  store data (rs2), LSB-aligned
memrd_in  in  1  load
memwr_in  in  1  store
funct3_in  in  3  access size/sign (RV32I encoding)
PC_step_in  in  BIT_W  PC+4, pass-through
rd_in  in  5  destination register
mem2reg_in, regwr_in, jump_in, mul_i  in  1 each  pass-through controls
alu_result_out, mem_dat, PC_step_out  out  BIT_W  MEM/WB register
rd_out  out  5  MEM/WB register
mem2reg_out, regwr_out, jump_out, mul_o, valid_out  out  1 each  MEM/WB register
misalign_o  out  1  registered: instruction in MEM/WB was a misaligned access
stall_o  out  1  combinational: hold all upstream stages
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1
DCACHE_stall  in  1  cache busy
DCACHE_ren, DCACHE_wen  out  1  request strobes
DCACHE_addr  out  BIT_W-2  word address = alu_result_in[BIT_W-1:2]
DCACHE_be  out  LANES  byte enables, bit i qualifies DCACHE_wdata[8i+7:8i]
DCACHE_rdata  in  BIT_W  read data
DCACHE_wdata  out  BIT_W  write data

Behaviour:
- off = alu_result_in[1:0]. misaligned = (memrd_in|memwr_in) & ((size==half & off[0]) | (size==word & off!=0)); size from funct3_in[1:0].
- req = valid_in & (memrd_in|memwr_in) & !misaligned. DCACHE_ren = req & memrd_in; DCACHE_wen = req & memwr_in. Both 0 when !req.
- Store lanes (memory byte order): SB be=0001<<off, data byte replicated to all lanes; SH be=0011<<off, half replicated to both halves; SW be=1111. With SWAP_ENDIAN=1, both DCACHE_wdata and DCACHE_be are lane-reversed (memory byte 0 -> bits [31:24], be[3]).
- Load: un-swap rdata, shift right by 8*off, then extend: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. funct3 011/110/111 are treated as LW.
- FSM IDLE/WAIT. IDLE: req & DCACHE_stall -> WAIT. WAIT: stays while DCACHE_stall; -> IDLE on !DCACHE_stall (the completing cycle). stall_o = req & DCACHE_stall, in both states. Upstream keeps inputs stable while stall_o=1; the cache request is re-presented each cycle unchanged.
- MEM/WB register: on stall_o=1 all outputs hold (no bubble insertion). Otherwise it captures the inputs, the extended load data into mem_dat (stores/non-memory: mem_dat = extended rdata, don't-care), and misalign_o = valid_in & misaligned.
- Misaligned or invalid entries: regwr_out=0, mem2reg_out=0; misaligned ones also set misalign_o=1 and valid_out=1 (for trap handling).
- flush & !stall_o: captured valid_out, regwr_out, mem2reg_out, jump_out, misalign_o = 0; the rest captured normally. A flush while stall_o=1 is ignored (the hazard unit must not issue one).
- stall_cnt_o increments each cycle stall_o=1 and saturates at all-ones.
- rst (sync, dominant): all MEM/WB outputs 0, misalign_o=0, FSM=IDLE, stall_cnt_o=0. Reset in WAIT aborts without a completion capture.
- Latency: 1 cycle from EX/MEM inputs to MEM/WB outputs, plus N cycles for N stall cycles.

Test Plan:
1. SWAP_ENDIAN=0, SB addr 0x1002, wdata 0x000000A5 -> be=0100, wdata=0xA5A5A5A5, addr=0x400; no stall.
2. LB addr 0x1003, rdata 0x80FF1234 (no swap) -> mem_dat=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x1002 -> 0x000080FF.
3. LW with DCACHE_stall high 3 cycles -> stall_o=1 for 3 cycles, outputs held, capture on the 4th, stall_cnt_o=3.
4. LH addr 0x1001 -> ren=0, next cycle misalign_o=1, regwr_out=0, valid_out=1; SW addr 0x1002 -> wen=0, misalign_o=1.
5. SWAP_ENDIAN=1, SH addr 0x2000, wdata 0x0000BEEF -> DCACHE_wdata=0xEFBEEFBE, be=1100.
6. flush with a valid load and no stall -> valid_out=0, regwr_out=0; rst asserted during WAIT -> all outputs 0, FSM IDLE next cycle.
